// File: rtl/cache_pkg.sv
// cache_pkg: widths, memory-arbiter state encoding and requester ids
// shared by the L2 / memory-side blocks.
package cache_pkg;
    localparam int TAG_W   = 18;
    localparam int INDEX_W = 8;
    localparam int LINE_W  = 512;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    localparam logic REQ_L2I = 1'b0;
    localparam logic REQ_L2D = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the served requester is masked
// for the single cycle after its completion so a still-held level is not re-served.
module rr_arbiter2
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       adv_id,
    output logic       gnt_valid,
    output logic       gnt_id
);
    logic       ptr;
    logic [1:0] mask;
    logic [1:0] elig;
    always_comb begin
        elig      = req & ~mask;
        gnt_valid = |elig;
        gnt_id    = (elig == 2'b11) ? ptr : elig[1];
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr  <= REQ_L2I;
            mask <= 2'b00;
        end else begin
            ptr  <= adv ? ~adv_id : ptr;
            mask <= adv ? (adv_id ? 2'b10 : 2'b01) : 2'b00;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory port between L2I and L2D, one
// transaction at a time, with a watchdog on memory latency.
module mem_arbiter
    import cache_pkg::*;
#(
    parameter int TAG_W   = cache_pkg::TAG_W,
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int LINE_W  = cache_pkg::LINE_W,
    parameter int TIMEOUT = 64
)(
    input  logic               clk,
    input  logic               rstn,
    input  logic               read_L2I_ARB,
    input  logic               write_L2I_ARB,
    input  logic [INDEX_W-1:0] index_L2I_ARB,
    input  logic [TAG_W-1:0]   tag_L2I_ARB,
    input  logic [LINE_W-1:0]  wdata_L2I_ARB,
    input  logic               read_L2D_ARB,
    input  logic               write_L2D_ARB,
    input  logic [INDEX_W-1:0] index_L2D_ARB,
    input  logic [TAG_W-1:0]   tag_L2D_ARB,
    input  logic [LINE_W-1:0]  wdata_L2D_ARB,
    output logic               ready_ARB_L2I,
    output logic               ready_ARB_L2D,
    output logic [LINE_W-1:0]  rdata_ARB_L2,
    output logic               err_ARB_L2,
    output logic               read_ARB_MEM,
    output logic               write_ARB_MEM,
    output logic [INDEX_W-1:0] index_ARB_MEM,
    output logic [TAG_W-1:0]   tag_ARB_MEM,
    output logic [LINE_W-1:0]  wdata_ARB_MEM,
    input  logic               ready_MEM_ARB,
    input  logic [LINE_W-1:0]  read_data_MEM_ARB
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    arb_state_t       state;
    logic             gid;
    logic [CNT_W-1:0] cnt;
    logic             gnt_valid;
    logic             gnt_id;
    rr_arbiter2 u_rr (
        .clk       (clk),
        .rstn      (rstn),
        .req       ({read_L2D_ARB | write_L2D_ARB, read_L2I_ARB | write_L2I_ARB}),
        .adv       (state == RESP),
        .adv_id    (gid),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );
    // The memory-side outputs double as the holding registers: loaded at grant, held through WAIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            gid           <= REQ_L2I;
            cnt           <= '0;
            read_ARB_MEM  <= 1'b0;
            write_ARB_MEM <= 1'b0;
            index_ARB_MEM <= '0;
            tag_ARB_MEM   <= '0;
            wdata_ARB_MEM <= '0;
            rdata_ARB_L2  <= '0;
            ready_ARB_L2I <= 1'b0;
            ready_ARB_L2D <= 1'b0;
            err_ARB_L2    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_valid) begin
                    gid           <= gnt_id;
                    read_ARB_MEM  <= gnt_id ? (read_L2D_ARB & ~write_L2D_ARB) : (read_L2I_ARB & ~write_L2I_ARB);
                    write_ARB_MEM <= gnt_id ? write_L2D_ARB : write_L2I_ARB;
                    index_ARB_MEM <= gnt_id ? index_L2D_ARB : index_L2I_ARB;
                    tag_ARB_MEM   <= gnt_id ? tag_L2D_ARB : tag_L2I_ARB;
                    wdata_ARB_MEM <= gnt_id ? wdata_L2D_ARB : wdata_L2I_ARB;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: if (ready_MEM_ARB || cnt == CNT_MAX) begin
                    read_ARB_MEM  <= 1'b0;
                    write_ARB_MEM <= 1'b0;
                    rdata_ARB_L2  <= (ready_MEM_ARB && !write_ARB_MEM) ? read_data_MEM_ARB : rdata_ARB_L2;
                    err_ARB_L2    <= !ready_MEM_ARB;
                    ready_ARB_L2I <= gid == REQ_L2I;
                    ready_ARB_L2D <= gid == REQ_L2D;
                    state         <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: begin
                    ready_ARB_L2I <= 1'b0;
                    ready_ARB_L2D <= 1'b0;
                    err_ARB_L2    <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model (pending requests, next-in-turn, last read line).
module tb_mem_arbiter;
    typedef struct {
        logic         wr;
        logic [7:0]   idx;
        logic [17:0]  tag;
        logic [511:0] wd;
        logic [511:0] rd;
    } mtx_t;
    logic clk = 1'b0;
    logic rstn;
    logic rq_rd [2];
    logic rq_wr [2];
    logic [7:0]   rq_idx [2];
    logic [17:0]  rq_tag [2];
    logic [511:0] rq_wd [2];
    logic         ready_ARB_L2I, ready_ARB_L2D, err_ARB_L2;
    logic [511:0] rdata_ARB_L2;
    logic         read_ARB_MEM, write_ARB_MEM;
    logic [7:0]   index_ARB_MEM;
    logic [17:0]  tag_ARB_MEM;
    logic [511:0] wdata_ARB_MEM;
    logic         ready_MEM_ARB;
    logic [511:0] read_data_MEM_ARB;
    int checks = 0;
    int passes = 0;
    mtx_t mem_log [$];
    int mem_lat = 0;
    bit mem_silent = 1'b0;
    bit mem_pattern = 1'b0;
    int hi_cnt = 0;
    logic         ex_wr [2];
    logic [7:0]   ex_idx [2];
    logic [17:0]  ex_tag [2];
    logic [511:0] ex_wd [2];
    int nxt = 0;
    logic [511:0] last_rd = '0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk               (clk),
        .rstn              (rstn),
        .read_L2I_ARB      (rq_rd[0]),
        .write_L2I_ARB     (rq_wr[0]),
        .index_L2I_ARB     (rq_idx[0]),
        .tag_L2I_ARB       (rq_tag[0]),
        .wdata_L2I_ARB     (rq_wd[0]),
        .read_L2D_ARB      (rq_rd[1]),
        .write_L2D_ARB     (rq_wr[1]),
        .index_L2D_ARB     (rq_idx[1]),
        .tag_L2D_ARB       (rq_tag[1]),
        .wdata_L2D_ARB     (rq_wd[1]),
        .ready_ARB_L2I     (ready_ARB_L2I),
        .ready_ARB_L2D     (ready_ARB_L2D),
        .rdata_ARB_L2      (rdata_ARB_L2),
        .err_ARB_L2        (err_ARB_L2),
        .read_ARB_MEM      (read_ARB_MEM),
        .write_ARB_MEM     (write_ARB_MEM),
        .index_ARB_MEM     (index_ARB_MEM),
        .tag_ARB_MEM       (tag_ARB_MEM),
        .wdata_ARB_MEM     (wdata_ARB_MEM),
        .ready_MEM_ARB     (ready_MEM_ARB),
        .read_data_MEM_ARB (read_data_MEM_ARB)
    );

    task automatic chk(input string tag, input logic [543:0] obs, input logic [543:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [511:0] rnd_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Memory model: logs each request, checks it stays stable, answers after
    // mem_lat extra WAIT cycles, or never when silent.
    initial begin
        mtx_t m;
        logic [543:0] hold;
        int hi;
        ready_MEM_ARB = 1'b0;
        read_data_MEM_ARB = '0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && (read_ARB_MEM || write_ARB_MEM)) begin
                chk("mem_op_excl", read_ARB_MEM & write_ARB_MEM, 1'b0);
                m.wr  = write_ARB_MEM;
                m.idx = index_ARB_MEM;
                m.tag = tag_ARB_MEM;
                m.wd  = wdata_ARB_MEM;
                m.rd  = mem_pattern ? {64{8'hA5}} : rnd_line();
                hold  = {write_ARB_MEM, read_ARB_MEM, index_ARB_MEM, tag_ARB_MEM, wdata_ARB_MEM};
                mem_log.push_back(m);
                hi = 1;
                if (mem_silent) begin
                    while ((read_ARB_MEM || write_ARB_MEM) && hi < 300) begin
                        @(negedge clk);
                        if (read_ARB_MEM || write_ARB_MEM) hi++;
                    end
                    hi_cnt = hi;
                end else begin
                    repeat (mem_lat + 1) begin
                        @(negedge clk);
                        chk("mem_hold", {write_ARB_MEM, read_ARB_MEM, index_ARB_MEM, tag_ARB_MEM, wdata_ARB_MEM}, hold);
                    end
                    ready_MEM_ARB = 1'b1;
                    read_data_MEM_ARB = m.rd;
                    @(negedge clk);
                    ready_MEM_ARB = 1'b0;
                    read_data_MEM_ARB = rnd_line();
                end
            end
        end
    end

    task automatic setreq(input int r, input int op, input logic [7:0] idx, input logic [17:0] tag, input logic [511:0] wd);
        rq_rd[r]  = op[0];
        rq_wr[r]  = op[1];
        rq_idx[r] = idx;
        rq_tag[r] = tag;
        rq_wd[r]  = wd;
        ex_wr[r]  = op[1];
        ex_idx[r] = idx;
        ex_tag[r] = tag;
        ex_wd[r]  = wd;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ready_ARB_L2I || ready_ARB_L2D) && n < budget);
    endtask

    // One completion for requester r; the requester keeps its level through the
    // cycle after ready, as a registered L2 controller would.
    task automatic serve(input int r, input logic tmo, input int budget, output int n);
        mtx_t m;
        logic [511:0] exp_rd;
        wait_ready(budget, n);
        chk("ready_pair", {ready_ARB_L2D, ready_ARB_L2I}, (r == 1) ? 2'b10 : 2'b01);
        chk("err", err_ARB_L2, tmo);
        chk("log_entry", mem_log.size() > 0, 1'b1);
        exp_rd = last_rd;
        if (mem_log.size() > 0) begin
            m = mem_log.pop_front();
            chk("mem_op", m.wr, ex_wr[r]);
            chk("mem_index", m.idx, ex_idx[r]);
            chk("mem_tag", m.tag, ex_tag[r]);
            if (ex_wr[r]) chk("mem_wdata", m.wd, ex_wd[r]);
            if (!ex_wr[r] && !tmo) exp_rd = m.rd;
        end
        chk("rdata", rdata_ARB_L2, exp_rd);
        last_rd = exp_rd;
        nxt = 1 - r;
        @(negedge clk);
        @(negedge clk);
        rq_rd[r] = 1'b0;
        rq_wr[r] = 1'b0;
    endtask

    task automatic quiet();
        int act = 0;
        repeat (4) begin
            @(negedge clk);
            act += int'(read_ARB_MEM | write_ARB_MEM | ready_ARB_L2I | ready_ARB_L2D);
        end
        chk("quiet", act, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        for (int r = 0; r < 2; r++) begin
            rq_rd[r] = 1'b0;
            rq_wr[r] = 1'b0;
        end
        @(negedge clk);
        mem_log.delete();
        nxt = 0;
        last_rd = '0;
        rstn = 1'b1;
    endtask

    initial begin
        int n;
        int sel;
        int f;
        for (int r = 0; r < 2; r++) begin
            rq_rd[r] = 1'b0;
            rq_wr[r] = 1'b0;
            rq_idx[r] = '0;
            rq_tag[r] = '0;
            rq_wd[r] = '0;
        end
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {read_ARB_MEM, write_ARB_MEM, ready_ARB_L2I, ready_ARB_L2D, err_ARB_L2}, 5'b0);
        chk("reset_addr", {index_ARB_MEM, tag_ARB_MEM}, 26'b0);
        chk("reset_wdata", wdata_ARB_MEM, 512'b0);
        chk("reset_rdata", rdata_ARB_L2, 512'b0);
        rstn = 1'b1;

        // single L2I read, minimum latency, A5 line
        mem_pattern = 1'b1;
        mem_lat = 0;
        @(negedge clk);
        setreq(0, 1, 8'h12, 18'h0, rnd_line());
        chk("pre_grant_read", read_ARB_MEM, 1'b0);
        @(negedge clk);
        chk("issue_op", {read_ARB_MEM, write_ARB_MEM}, 2'b10);
        chk("issue_index", index_ARB_MEM, 8'h12);
        chk("issue_tag", tag_ARB_MEM, 18'h0);
        serve(0, 1'b0, 20, n);
        chk("turnaround", n, 2);
        chk("rdata_pattern", rdata_ARB_L2, {64{8'hA5}});
        mem_pattern = 1'b0;
        quiet();

        // simultaneous pair after reset, then pointer flip
        do_reset();
        mem_lat = 1;
        setreq(0, 1, 8'($urandom), 18'($urandom), rnd_line());
        setreq(1, 2, 8'($urandom), 18'($urandom), rnd_line());
        serve(0, 1'b0, 20, n);
        serve(1, 1'b0, 20, n);
        quiet();
        setreq(0, 2, 8'($urandom), 18'($urandom), rnd_line());
        serve(0, 1'b0, 20, n);
        quiet();
        setreq(0, 1, 8'($urandom), 18'($urandom), rnd_line());
        setreq(1, 1, 8'($urandom), 18'($urandom), rnd_line());
        serve(1, 1'b0, 20, n);
        serve(0, 1'b0, 20, n);
        quiet();

        // L2D write, inputs scrambled and request dropped right after grant
        mem_lat = 3;
        setreq(1, 2, 8'h5A, 18'h2AAAA, {16{32'hDEADBEEF}});
        @(posedge clk);
        #1;
        rq_idx[1] = 8'hA5;
        rq_tag[1] = 18'h15555;
        rq_wd[1] = rnd_line();
        rq_wr[1] = 1'b0;
        serve(1, 1'b0, 20, n);
        quiet();

        // memory never answers
        mem_silent = 1'b1;
        setreq(0, 1, 8'($urandom), 18'($urandom), rnd_line());
        serve(0, 1'b1, 100, n);
        chk("timeout_cycles", hi_cnt, 65);
        mem_silent = 1'b0;
        quiet();
        mem_lat = 0;
        setreq(1, 1, 8'($urandom), 18'($urandom), rnd_line());
        serve(1, 1'b0, 20, n);
        quiet();

        // read and write both high on L2I
        setreq(0, 3, 8'($urandom), 18'($urandom), rnd_line());
        serve(0, 1'b0, 20, n);
        quiet();

        // async reset during WAIT abandons the transaction
        mem_silent = 1'b1;
        setreq(0, 1, 8'($urandom), 18'($urandom), rnd_line());
        repeat (5) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_ctrl", {read_ARB_MEM, write_ARB_MEM, ready_ARB_L2I, ready_ARB_L2D, err_ARB_L2}, 5'b0);
        chk("async_reset_addr", {index_ARB_MEM, tag_ARB_MEM}, 26'b0);
        chk("async_reset_wdata", wdata_ARB_MEM, 512'b0);
        chk("async_reset_rdata", rdata_ARB_L2, 512'b0);
        rq_rd[0] = 1'b0;
        setreq(1, 2, 8'($urandom), 18'($urandom), rnd_line());
        @(negedge clk);
        @(negedge clk);
        mem_log.delete();
        mem_silent = 1'b0;
        nxt = 0;
        last_rd = '0;
        rstn = 1'b1;
        serve(1, 1'b0, 20, n);
        quiet();

        // randomized rounds against the model
        repeat (24) begin
            mem_lat = $urandom_range(0, 3);
            sel = $urandom_range(1, 3);
            for (int r = 0; r < 2; r++)
                if (sel[r]) setreq(r, $urandom_range(1, 3), 8'($urandom), 18'($urandom), rnd_line());
            if (sel == 3) begin
                f = nxt;
                serve(f, 1'b0, 20, n);
                serve(1 - f, 1'b0, 20, n);
            end else begin
                serve(sel[1] ? 1 : 0, 1'b0, 20, n);
            end
            quiet();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
